axi_mem_slave: RTL

//  AXI4 terminating slave (responder) backed by an internal register-array memory.

---
 rtl/axi_mem_slave.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_slave.sv
// axi_mem_slave
//   AXI4 terminating slave backed by an internal register-array memory, used as a
//   scratchpad / test target at the far end of an AXI path. Supports FIXED, INCR and
//   WRAP bursts and narrow transfers. One write and one read burst are in flight at a
//   time; the two directions are independent.
//
// Optional feature (compile-time macro AXI_MEM_SLAVE_RANGE_CHECK_EN):
//   defined   - a burst starting at or above MEM_WORDS*DATA_WIDTH/8 is answered with
//               SLVERR on every beat; its writes are dropped and its reads return 0.
//   undefined - upper address bits are ignored and the memory aliases.
//
// Ports
//   clk, rstn                     clock, async active-low reset
//   aw_*  (valid/ready/id/addr/len/size/burst)  write address channel
//   w_*   (valid/ready/data/strb/last)          write data channel
//   b_*   (valid/ready/id/resp/user)            write response channel
//   ar_*  (valid/ready/id/addr/len/size/burst)  read address channel
//   r_*   (valid/ready/id/data/resp/last/user)  read data channel
//   All outputs are registered; user outputs are tied to 0.

module axi_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    // AW
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [ID_WIDTH-1:0]     aw_id,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]              aw_len,
    input  logic [2:0]              aw_size,
    input  logic [1:0]              aw_burst,
    // W
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    w_last,
    // B
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [ID_WIDTH-1:0]     b_id,
    output logic [1:0]              b_resp,
    output logic [USER_WIDTH-1:0]   b_user,
    // AR
    input  logic                    ar_valid,
    output logic                    ar_ready,
    input  logic [ID_WIDTH-1:0]     ar_id,
    input  logic [ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]              ar_len,
    input  logic [2:0]              ar_size,
    input  logic [1:0]              ar_burst,
    // R
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [ID_WIDTH-1:0]     r_id,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic [1:0]              r_resp,
    output logic                    r_last,
    output logic [USER_WIDTH-1:0]   r_user
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Whole-burst errors that also suppress data: reserved burst type or a beat
    // wider than the bus.
    function automatic logic attr_bad(input logic [2:0] size, input logic [1:0] burst);
        return (burst == 2'b11) || (int'(size) > LSB);
    endfunction

    // Address of the following beat, on the byte address. WRAP keeps the bits
    // above the container and rolls the offset inside it; an illegal WRAP
    // length degrades to INCR (its error is flagged separately).
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [2:0]            size,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] inc, sum, mask;
        inc  = ADDR_WIDTH'(1) << size;
        sum  = a + inc;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b01:   return sum;
            2'b10:   return wrap_len_ok(len) ? ((a & ~mask) | (sum & mask)) : sum;
            default: return a;
        endcase
    endfunction

    // ---------------------------------------------------------------- decode
    logic aw_oor, ar_oor;
`ifdef AXI_MEM_SLAVE_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH:0] MEM_TOP = (ADDR_WIDTH+1)'(MEM_WORDS * STRB_W);
    assign aw_oor = {1'b0, aw_addr} >= MEM_TOP;
    assign ar_oor = {1'b0, ar_addr} >= MEM_TOP;
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    logic aw_kill, aw_err, ar_kill, ar_err;
    assign aw_kill = attr_bad(aw_size, aw_burst) || aw_oor;
    assign aw_err  = aw_kill || ((aw_burst == 2'b10) && !wrap_len_ok(aw_len));
    assign ar_kill = attr_bad(ar_size, ar_burst) || ar_oor;
    assign ar_err  = ar_kill || ((ar_burst == 2'b10) && !wrap_len_ok(ar_len));

    assign b_user = '0;
    assign r_user = '0;

    // ================================================================ write
    w_state_t              w_state, w_state_d;
    logic                  aw_ready_d, w_ready_d, b_valid_d;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_kill, w_err;

    logic aw_fire, w_fire, w_final, w_err_nxt, b_fire;
    logic [IDX_W-1:0] w_idx;

    assign aw_fire   = aw_valid && aw_ready;
    assign w_fire    = w_valid && w_ready;
    assign b_fire    = b_valid && b_ready;
    assign w_final   = w_fire && (w_cnt == w_len);
    // w_last is required exactly on the final beat; any other placement is sticky SLVERR.
    assign w_err_nxt = w_err || (w_last != (w_cnt == w_len));
    assign w_idx     = w_addr[LSB +: IDX_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) w_state <= W_IDLE;
        else       w_state <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_state_d = W_DATA;
            W_DATA:  if (w_final) w_state_d = W_RESP;
            W_RESP:  if (b_fire)  w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state and registered, so they
    // stay low through reset and come up one edge after release.
    always_comb begin
        aw_ready_d = (w_state_d == W_IDLE);
        w_ready_d  = (w_state_d == W_DATA);
        b_valid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_id     <= '0;
            b_resp   <= RESP_OKAY;
            w_addr   <= '0;
            w_len    <= '0;
            w_cnt    <= '0;
            w_size   <= '0;
            w_burst  <= '0;
            w_kill   <= 1'b0;
            w_err    <= 1'b0;
        end else begin
            aw_ready <= aw_ready_d;
            w_ready  <= w_ready_d;
            b_valid  <= b_valid_d;
            if (aw_fire) begin
                b_id    <= aw_id;
                w_addr  <= aw_addr;
                w_len   <= aw_len;
                w_size  <= aw_size;
                w_burst <= aw_burst;
                w_cnt   <= '0;
                w_kill  <= aw_kill;
                w_err   <= aw_err;
            end
            if (w_fire) begin
                w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                w_err  <= w_err_nxt;
                if (w_final) b_resp <= w_err_nxt ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Memory is not reset. Byte lanes are taken straight from w_strb.
    always_ff @(posedge clk) begin
        if (w_fire && !w_kill) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) mem[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
    end

    // ================================================================ read
    r_state_t              r_state, r_state_d;
    logic                  ar_ready_d, r_valid_d;
    logic [ADDR_WIDTH-1:0] r_addr;   // address of the beat to fetch next
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_kill;

    logic ar_fire, r_fire, r_adv;
    logic [IDX_W-1:0] ar_idx, r_idx;

    assign ar_fire = ar_valid && ar_ready;
    assign r_fire  = r_valid && r_ready;
    assign r_adv   = r_fire && !r_last;
    assign ar_idx  = ar_addr[LSB +: IDX_W];
    assign r_idx   = r_addr[LSB +: IDX_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= R_IDLE;
        else       r_state <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire)          r_state_d = R_DATA;
            R_DATA:  if (r_fire && r_last) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        ar_ready_d = (r_state_d == R_IDLE);
        r_valid_d  = (r_state_d == R_DATA);
    end

    // Beats are fetched in the same edge that accepts AR or the previous beat, so
    // the stream has no bubbles. A write to the same word in that edge is not seen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
            r_last   <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_kill   <= 1'b0;
        end else begin
            ar_ready <= ar_ready_d;
            r_valid  <= r_valid_d;
            if (ar_fire) begin
                r_id    <= ar_id;
                r_data  <= ar_kill ? '0 : mem[ar_idx];
                r_resp  <= ar_err ? RESP_SLVERR : RESP_OKAY;
                r_last  <= (ar_len == 8'd0);
                r_addr  <= next_addr(ar_addr, ar_size, ar_len, ar_burst);
                r_len   <= ar_len;
                r_size  <= ar_size;
                r_burst <= ar_burst;
                r_cnt   <= '0;
                r_kill  <= ar_kill;
            end else if (r_adv) begin
                r_data <= r_kill ? '0 : mem[r_idx];
                r_addr <= next_addr(r_addr, r_size, r_len, r_burst);
                r_cnt  <= r_cnt + 8'd1;
                r_last <= ((r_cnt + 8'd1) == r_len);
            end else if (r_fire) begin
                r_last <= 1'b0;
            end
        end
    end

endmodule
